// File: rtl/brick_pkg.sv
// Shared geometry, palette and types for the brick renderer and its counter.
package brick_pkg;

    localparam int BRICK_W    = 32;
    localparam int BRICK_H    = 20;
    localparam int COLS       = 20;
    localparam int ROWS       = 24;
    localparam int NUM_BRICKS = 480;
    localparam int BRICK_BITS = 3;
    localparam int MAP_BITS   = NUM_BRICKS * BRICK_BITS;

    typedef logic [BRICK_BITS-1:0] brick_t;
    typedef logic [MAP_BITS-1:0]   brick_map_t;

    // 4:4:4 colour per brick type; entry 0 is never displayed (empty cell).
    localparam logic [11:0] PALETTE [8] = '{
        12'h000, 12'hF00, 12'hF80, 12'hFF0,
        12'h0F0, 12'h0FF, 12'h00F, 12'hF0F
    };

    // Pixel pipeline stage-1 contents.
    typedef struct packed {
        logic [4:0] col;
        logic [4:0] row;
        logic [4:0] x_off;
        logic [4:0] y_off;
        logic       in_area;
    } pix_s1_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

    // Extract brick `idx` from a packed map.
    function automatic brick_t brick_at(input brick_map_t map, input logic [8:0] idx);
        return map[int'(idx) * BRICK_BITS +: BRICK_BITS];
    endfunction

endpackage

// File: rtl/brick_counter.sv
// Walks the shadow brick map one cell per cycle and reports how many
// non-empty bricks remain. A new start always restarts from cell 0.
module brick_counter
    import brick_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  brick_map_t shadow,
    output logic [8:0] bricks_left,
    output logic       scan_done,
    output logic       level_clear
);

    scan_state_t state;
    logic [8:0]  idx;
    logic [8:0]  acc;

    // Scan FSM with registered result and one-cycle completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= '0;
            bricks_left <= '0;
            scan_done   <= 1'b0;
            level_clear <= 1'b0;
        end else begin
            scan_done   <= 1'b0;
            level_clear <= 1'b0;
            if (start) begin
                // A start in any state discards the running count; the
                // previous bricks_left stays visible until the new scan ends.
                state <= SCAN;
                idx   <= '0;
                acc   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    SCAN: begin
                        if (brick_at(shadow, idx) != '0) begin
                            acc <= acc + 9'd1;
                        end
                        if (idx == 9'(NUM_BRICKS - 1)) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + 9'd1;
                        end
                    end
                    DONE: begin
                        bricks_left <= acc;
                        scan_done   <= 1'b1;
                        level_clear <= (acc == '0);
                        state       <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/brick_renderer.sv
// Brick-wall renderer: snapshots the live map at vertical blanking, draws
// bricks with a two-stage pixel pipeline, and counts remaining bricks.
module brick_renderer
    import brick_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [MAP_BITS-1:0] bricks,
    input  logic                frame_start,
    input  logic [9:0]          h_cnt,
    input  logic [9:0]          v_cnt,
    input  logic                valid,
    output logic [11:0]         pixel_rgb,
    output logic                pixel_hit,
    output logic [8:0]          bricks_left,
    output logic                scan_done,
    output logic                level_clear
);

    brick_map_t shadow;
    pix_s1_t    s1_next;
    pix_s1_t    s1;
    logic [8:0] pix_idx;
    brick_t     pix_brick;
    logic       mortar;

    // Frame snapshot so a mid-frame map update never tears the picture.
    // NOTE: the shadow is a plain register, not a RAM, so it can and must be reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (frame_start) begin
            // NOTE: non-blocking so every reader in this edge sees the old value.
            shadow <= bricks;
        end
    end

    // Split the raster position into brick cell and in-brick offset.
    always_comb begin
        // NOTE: default the whole struct first so no path infers a latch.
        s1_next         = '0;
        s1_next.col     = h_cnt[9:5];
        s1_next.row     = 5'(v_cnt / 10'd20);
        s1_next.x_off   = h_cnt[4:0];
        s1_next.y_off   = 5'(v_cnt % 10'd20);
        s1_next.in_area = valid && (h_cnt < 10'd640) && (v_cnt < 10'd480);
    end

    // Stage 1: register geometry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
        end else begin
            s1 <= s1_next;
        end
    end

    // Look up the brick under the stage-1 pixel; off-screen positions use
    // cell 0 so the index never leaves the map (the result is gated anyway).
    always_comb begin
        pix_idx = '0;
        if (s1.in_area) begin
            pix_idx = 9'(int'(s1.col) + COLS * int'(s1.row));
        end
        pix_brick = brick_at(shadow, pix_idx);
        mortar    = (s1.x_off == 5'd0) || (s1.x_off == 5'(BRICK_W - 1)) ||
                    (s1.y_off == 5'd0) || (s1.y_off == 5'(BRICK_H - 1));
    end

    // Stage 2: registered colour and hit flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_rgb <= '0;
            pixel_hit <= 1'b0;
        end else if (!s1.in_area || pix_brick == '0) begin
            pixel_rgb <= '0;
            pixel_hit <= 1'b0;
        end else if (mortar) begin
            pixel_rgb <= '0;
            pixel_hit <= 1'b1;
        end else begin
            pixel_rgb <= PALETTE[pix_brick];
            pixel_hit <= 1'b1;
        end
    end

    brick_counter u_counter (
        .clk         (clk),
        .rst         (rst),
        .start       (frame_start),
        .shadow      (shadow),
        .bricks_left (bricks_left),
        .scan_done   (scan_done),
        .level_clear (level_clear)
    );

endmodule

// File: tb/tb_brick_renderer.sv
// Self-checking bench for brick_renderer: random pixels against a
// geometric reference model, plus scan timing, abort and reset scenarios.
module tb_brick_renderer;

    logic          clk = 1'b0;
    logic          rst;
    logic [1439:0] bricks;
    logic          frame_start;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          valid;
    logic [11:0]   pixel_rgb;
    logic          pixel_hit;
    logic [8:0]    bricks_left;
    logic          scan_done;
    logic          level_clear;

    int n_cmp = 0;
    int n_bad = 0;

    int live_map   [480];
    int shadow_map [480];
    int exp_bl_last = 0;

    logic [11:0] pal [8] = '{12'h000, 12'hF00, 12'hF80, 12'hFF0,
                             12'h0F0, 12'h0FF, 12'h00F, 12'hF0F};

    brick_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .bricks      (bricks),
        .frame_start (frame_start),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .valid       (valid),
        .pixel_rgb   (pixel_rgb),
        .pixel_hit   (pixel_hit),
        .bricks_left (bricks_left),
        .scan_done   (scan_done),
        .level_clear (level_clear)
    );

    always #5 clk = ~clk;

    // Reference: what the screen should show at (h, v) for the snapshot map.
    function automatic logic [12:0] exp_pixel(int h, int v, bit vld);
        int b, xo, yo;
        if (!vld || h >= 640 || v >= 480) return 13'h0;
        b = shadow_map[(h / 32) + 20 * (v / 20)];
        if (b == 0) return 13'h0;
        xo = h % 32;
        yo = v % 20;
        if (xo == 0 || xo == 31 || yo == 0 || yo == 19) return {1'b1, 12'h000};
        return {1'b1, pal[b]};
    endfunction

    function automatic int count_shadow();
        int c = 0;
        for (int i = 0; i < 480; i++) if (shadow_map[i] != 0) c++;
        return c;
    endfunction

    task automatic drive_live();
        for (int i = 0; i < 480; i++) bricks[3*i +: 3] = 3'(live_map[i]);
    endtask

    task automatic clear_live();
        for (int i = 0; i < 480; i++) live_map[i] = 0;
    endtask

    // Pulse frame_start for one cycle; on return one rising edge has sampled it.
    task automatic pulse_start();
        drive_live();
        frame_start = 1'b1;
        for (int i = 0; i < 480; i++) shadow_map[i] = live_map[i];
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Present one pixel and return what the DUT shows two edges later.
    task automatic drive_pixel(input int h, input int v, input bit vld, output logic [12:0] obs);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        valid = vld;
        @(negedge clk);
        valid = 1'b0;
        h_cnt = '0;
        v_cnt = '0;
        @(negedge clk);
        obs = {pixel_hit, pixel_rgb};
    endtask

    // Observe counter outputs for edge counts from_n..to_n (bounded).
    task automatic watch_scan(input int from_n, input int to_n, output int pulse_n,
                              output int pulse_cnt, output int lc_cnt,
                              output logic [8:0] bl_at, output logic lc_at);
        pulse_n   = -1;
        pulse_cnt = 0;
        lc_cnt    = 0;
        bl_at     = 'x;
        lc_at     = 1'bx;
        for (int n = from_n; n <= to_n; n++) begin
            if (scan_done === 1'b1) begin
                pulse_cnt++;
                if (pulse_n < 0) begin
                    pulse_n = n;
                    bl_at   = bricks_left;
                    lc_at   = level_clear;
                end
            end
            if (level_clear === 1'b1) lc_cnt++;
            if (n < to_n) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({pixel_rgb, pixel_hit, bricks_left, scan_done, level_clear} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_state: rgb=%03h hit=%b left=%0d done=%b clear=%b, want all 0",
                     pixel_rgb, pixel_hit, bricks_left, scan_done, level_clear);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [12:0] obs, e;
        clear_live();
        live_map[0] = 5;
        pulse_start();
        drive_pixel(10, 10, 1'b1, obs);
        e = {1'b1, pal[5]};
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL body_pixel: got %04h want %04h", obs, e); end
        drive_pixel(0, 5, 1'b1, obs);
        n_cmp++;
        if (obs !== 13'h1000) begin n_bad++; $display("FAIL mortar_pixel: got %04h want 1000", obs); end
        drive_pixel(640, 10, 1'b1, obs);
        n_cmp++;
        if (obs !== 13'h0) begin n_bad++; $display("FAIL h640_pixel: got %04h want 0000", obs); end
        drive_pixel(10, 10, 1'b0, obs);
        n_cmp++;
        if (obs !== 13'h0) begin n_bad++; $display("FAIL invalid_pixel: got %04h want 0000", obs); end

        clear_live();
        live_map[479] = 2;
        pulse_start();
        drive_pixel(620, 465, 1'b1, obs);
        e = {1'b1, pal[2]};
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL last_brick: got %04h want %04h", obs, e); end
        drive_pixel(620, 459, 1'b1, obs);
        n_cmp++;
        if (obs !== 13'h0) begin n_bad++; $display("FAIL row22_empty: got %04h want 0000", obs); end
    endtask

    task automatic test_random_pixels();
        localparam int N = 400;
        logic [12:0] expq [$];
        logic [12:0] e;
        int h, v, pn, pc, lc, exp_cnt;
        bit vld;
        logic [8:0] bl;
        logic la;
        for (int i = 0; i < 480; i++) live_map[i] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
        pulse_start();
        for (int k = 0; k < N + 2; k++) begin
            if (k >= 2) begin
                e = expq.pop_front();
                n_cmp++;
                if ({pixel_hit, pixel_rgb} !== e) begin
                    n_bad++;
                    $display("FAIL random_pixel[%0d]: got %04h want %04h", k - 2, {pixel_hit, pixel_rgb}, e);
                end
            end
            if (k < N) begin
                h   = $urandom_range(0, 700);
                v   = $urandom_range(0, 520);
                vld = ($urandom_range(0, 7) != 0);
                h_cnt = 10'(h);
                v_cnt = 10'(v);
                valid = vld;
                expq.push_back(exp_pixel(h, v, vld));
            end else begin
                valid = 1'b0;
            end
            @(negedge clk);
        end
        exp_cnt = count_shadow();
        watch_scan(N + 3, 490, pn, pc, lc, bl, la);
        n_cmp++;
        if (pn != 482 || pc != 1 || bl !== 9'(exp_cnt)) begin
            n_bad++;
            $display("FAIL random_count: pulse at %0d x%0d left=%0d, want at 482 x1 left=%0d", pn, pc, bl, exp_cnt);
        end
        exp_bl_last = exp_cnt;
    endtask

    task automatic test_count();
        int placed, idx, pn, pc, lc;
        logic [8:0] bl;
        logic la;
        clear_live();
        placed = 0;
        for (int t = 0; t < 20000 && placed < 37; t++) begin
            idx = $urandom_range(0, 479);
            if (live_map[idx] == 0) begin
                live_map[idx] = $urandom_range(1, 7);
                placed++;
            end
        end
        pulse_start();
        watch_scan(1, 490, pn, pc, lc, bl, la);
        n_cmp++;
        if (pn != 482 || pc != 1) begin
            n_bad++;
            $display("FAIL count37_timing: pulse at %0d x%0d, want at 482 x1", pn, pc);
        end
        n_cmp++;
        if (bl !== 9'd37 || la !== 1'b0 || lc != 0) begin
            n_bad++;
            $display("FAIL count37_value: left=%0d clear=%b clear_cycles=%0d, want 37 0 0", bl, la, lc);
        end
        exp_bl_last = 37;
    endtask

    task automatic test_empty();
        int pn, pc, lc;
        logic [8:0] bl;
        logic la;
        logic [12:0] obs, e;
        clear_live();
        pulse_start();
        watch_scan(1, 490, pn, pc, lc, bl, la);
        n_cmp++;
        if (pn != 482 || pc != 1 || bl !== 9'd0 || la !== 1'b1 || lc != 1) begin
            n_bad++;
            $display("FAIL empty_scan: pulse at %0d x%0d left=%0d clear=%b clear_cycles=%0d, want 482 x1 0 1 1",
                     pn, pc, bl, la, lc);
        end
        // Change the live map without a snapshot: nothing visible may move.
        for (int i = 0; i < 480; i++) live_map[i] = 4;
        drive_live();
        drive_pixel(10, 10, 1'b1, obs);
        n_cmp++;
        if (obs !== 13'h0) begin n_bad++; $display("FAIL no_tear_pixel: got %04h want 0000", obs); end
        watch_scan(0, 50, pn, pc, lc, bl, la);
        n_cmp++;
        if (pc != 0 || bricks_left !== 9'd0) begin
            n_bad++;
            $display("FAIL no_tear_count: pulses=%0d left=%0d, want 0 0", pc, bricks_left);
        end
        // Full map: maximum count must not wrap.
        pulse_start();
        watch_scan(1, 490, pn, pc, lc, bl, la);
        n_cmp++;
        if (pn != 482 || bl !== 9'd480 || la !== 1'b0) begin
            n_bad++;
            $display("FAIL full_count: pulse at %0d left=%0d clear=%b, want 482 480 0", pn, bl, la);
        end
        exp_bl_last = 480;
        drive_pixel(10, 10, 1'b1, obs);
        e = {1'b1, pal[4]};
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL new_frame_pixel: got %04h want %04h", obs, e); end
    endtask

    task automatic test_back_to_back();
        int pn, pc, lc, exp_cnt;
        logic [8:0] bl;
        logic la;
        for (int i = 0; i < 480; i++) live_map[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
        pulse_start();
        watch_scan(1, 100, pn, pc, lc, bl, la);
        n_cmp++;
        if (pc != 0 || bricks_left !== 9'(exp_bl_last)) begin
            n_bad++;
            $display("FAIL abort_hold: pulses=%0d left=%0d, want 0 %0d", pc, bricks_left, exp_bl_last);
        end
        for (int i = 0; i < 480; i++) live_map[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 7) : 0;
        pulse_start();
        exp_cnt = count_shadow();
        watch_scan(1, 490, pn, pc, lc, bl, la);
        n_cmp++;
        if (pn != 482 || pc != 1 || bl !== 9'(exp_cnt)) begin
            n_bad++;
            $display("FAIL restart_scan: pulse at %0d x%0d left=%0d, want 482 x1 %0d", pn, pc, bl, exp_cnt);
        end
        exp_bl_last = exp_cnt;
    endtask

    task automatic test_reset_midscan();
        int pn, pc, lc, exp_cnt;
        logic [8:0] bl;
        logic la;
        logic [12:0] e;
        for (int i = 0; i < 480; i++) live_map[i] = $urandom_range(0, 7);
        live_map[0] = 3;
        pulse_start();
        h_cnt = 10'd10;
        v_cnt = 10'd10;
        valid = 1'b1;
        watch_scan(1, 50, pn, pc, lc, bl, la);
        e = exp_pixel(10, 10, 1'b1);
        n_cmp++;
        if ({pixel_hit, pixel_rgb} !== e || pc != 0) begin
            n_bad++;
            $display("FAIL pre_reset: got %04h pulses=%0d, want %04h 0", {pixel_hit, pixel_rgb}, pc, e);
        end
        rst = 1'b1;
        for (int i = 0; i < 480; i++) shadow_map[i] = 0;
        #1;
        n_cmp++;
        if ({pixel_rgb, pixel_hit, bricks_left, scan_done, level_clear} !== 24'h0) begin
            n_bad++;
            $display("FAIL midscan_reset: rgb=%03h hit=%b left=%0d done=%b clear=%b, want all 0",
                     pixel_rgb, pixel_hit, bricks_left, scan_done, level_clear);
        end
        @(negedge clk);
        rst = 1'b0;
        watch_scan(0, 600, pn, pc, lc, bl, la);
        n_cmp++;
        if (pc != 0 || lc != 0 || bricks_left !== 9'd0 || pixel_hit !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_quiet: pulses=%0d clears=%0d left=%0d hit=%b, want 0 0 0 0",
                     pc, lc, bricks_left, pixel_hit);
        end
        valid = 1'b0;
        pulse_start();
        exp_cnt = count_shadow();
        watch_scan(1, 490, pn, pc, lc, bl, la);
        n_cmp++;
        if (pn != 482 || pc != 1 || bl !== 9'(exp_cnt)) begin
            n_bad++;
            $display("FAIL post_reset_scan: pulse at %0d x%0d left=%0d, want 482 x1 %0d", pn, pc, bl, exp_cnt);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bricks      = '0;
        frame_start = 1'b0;
        h_cnt       = '0;
        v_cnt       = '0;
        valid       = 1'b0;
        for (int i = 0; i < 480; i++) begin
            live_map[i]   = 0;
            shadow_map[i] = 0;
        end
        @(negedge clk);
        test_reset();
        test_directed();
        test_random_pixels();
        test_count();
        test_empty();
        test_back_to_back();
        test_reset_midscan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
